// File: rtl/iob_wq.sv
`default_nettype none
// ============================================================================
// Module      : iob_wq
// Description : Two-entry posted-write queue between the FSB slave and the
//               IOB master, with issue FSM, watchdog and sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module iob_wq #(
    parameter int TMO = 255
) (
    input  logic       FCLK,
    input  logic       nRESin,
    input  logic       PostReq,
    input  logic       PostL,
    input  logic       PostU,
    output logic       PostRdy,
    input  logic       RdReq,
    output logic       RdGnt,
    output logic       ALE0,
    output logic       ALE1,
    output logic       IOWRREQ,
    output logic       IOL0,
    output logic       IOU0,
    input  logic       IOACT,
    input  logic       IODONE,
    input  logic       IOBERR,
    output logic [1:0] Level,
    output logic       WrErr,
    input  logic       ErrClr
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_ACT  = 2'd2;
    localparam logic [7:0] c_TMO  = 8'(TMO);

    logic       r_v0, r_l0, r_u0;
    logic       r_v1, r_l1, r_u1;
    logic [1:0] r_state;
    logic [7:0] r_cnt;
    logic       r_wrErr;
    logic       r_ale1;

    logic       w_accept;
    logic       w_transfer;
    logic       w_retire;
    logic       w_timeout;
    logic       w_errSet;
    logic       w_tmoHit;
    logic [7:0] w_cntInc;

    // Reads are only granted once every posted write has fully drained.
    assign RdGnt      = RdReq && !r_v0 && !r_v1 && (r_state == c_IDLE);
    assign PostRdy    = !r_v0 && !RdGnt;
    assign w_accept   = PostReq && PostRdy;
    assign ALE0       = w_accept;
    assign ALE1       = r_ale1;
    assign w_transfer = r_v0 && !r_v1;

    assign w_cntInc   = r_cnt + 8'd1;
    assign w_tmoHit   = (w_cntInc == c_TMO);
    assign w_retire   = (r_state == c_ACT) && IODONE;
    assign w_timeout  = w_tmoHit && (((r_state == c_REQ) && !IOACT) ||
                                     ((r_state == c_ACT) && !IODONE));
    assign w_errSet   = (w_retire && IOBERR) || w_timeout;

    assign IOWRREQ    = (r_state == c_REQ);
    assign IOL0       = IOWRREQ && r_l1;
    assign IOU0       = IOWRREQ && r_u1;
    assign Level      = {1'b0, r_v0} + {1'b0, r_v1};
    assign WrErr      = r_wrErr;

    always_ff @(posedge FCLK or negedge nRESin) begin
        if (!nRESin) begin
            r_v0    <= 1'b0;
            r_l0    <= 1'b0;
            r_u0    <= 1'b0;
            r_v1    <= 1'b0;
            r_l1    <= 1'b0;
            r_u1    <= 1'b0;
            r_state <= c_IDLE;
            r_cnt   <= 8'd0;
            r_wrErr <= 1'b0;
            r_ale1  <= 1'b0;
        end else begin
            r_ale1 <= w_transfer;

            // Retire and transfer are mutually exclusive: retire needs V1 set.
            if (w_retire || w_timeout) begin
                r_v1 <= 1'b0;
            end
            if (w_transfer) begin
                r_v1 <= 1'b1;
                r_l1 <= r_l0;
                r_u1 <= r_u0;
                r_v0 <= 1'b0;
            end else if (w_accept) begin
                r_v0 <= 1'b1;
                r_l0 <= PostL;
                r_u0 <= PostU;
            end

            case (r_state)
                c_IDLE: begin
                    r_cnt <= 8'd0;
                    if (r_v1) begin
                        r_state <= c_REQ;
                    end
                end
                c_REQ: begin
                    if (IOACT) begin
                        r_state <= c_ACT;
                        r_cnt   <= 8'd0;
                    end else if (w_tmoHit) begin
                        r_state <= c_IDLE;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= w_cntInc;
                    end
                end
                c_ACT: begin
                    if (IODONE || w_tmoHit) begin
                        r_state <= c_IDLE;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= w_cntInc;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= 8'd0;
                end
            endcase

            if (w_errSet) begin
                r_wrErr <= 1'b1;
            end else if (ErrClr) begin
                r_wrErr <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iob_wq.sv
`default_nettype none
// ============================================================================
// Module      : tb_iob_wq
// Description : Randomised scoreboard bench for iob_wq against a queue-based
//               reference model of the posted-write pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iob_wq;

    localparam int TMO_TB = 4;
    localparam int NCYC   = 3000;
    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_ACT  = 2;

    logic       FCLK;
    logic       nRESin;
    logic       PostReq, PostL, PostU, PostRdy;
    logic       RdReq, RdGnt;
    logic       ALE0, ALE1;
    logic       IOWRREQ, IOL0, IOU0;
    logic       IOACT, IODONE, IOBERR;
    logic [1:0] Level;
    logic       WrErr, ErrClr;

    iob_wq #(.TMO(TMO_TB)) dut (
        .FCLK    (FCLK),
        .nRESin  (nRESin),
        .PostReq (PostReq),
        .PostL   (PostL),
        .PostU   (PostU),
        .PostRdy (PostRdy),
        .RdReq   (RdReq),
        .RdGnt   (RdGnt),
        .ALE0    (ALE0),
        .ALE1    (ALE1),
        .IOWRREQ (IOWRREQ),
        .IOL0    (IOL0),
        .IOU0    (IOU0),
        .IOACT   (IOACT),
        .IODONE  (IODONE),
        .IOBERR  (IOBERR),
        .Level   (Level),
        .WrErr   (WrErr),
        .ErrClr  (ErrClr)
    );

    initial FCLK = 1'b0;
    always #5 FCLK = ~FCLK;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit l;
        bit u;
        bit s1;
    } ent_t;

    ent_t       ent[$];
    logic [7:0] expQ[$];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic checkReset(input string tag);
        chk({tag, "_level"},   {6'd0, Level}, 8'd0);
        chk({tag, "_rdgnt"},   {7'd0, RdGnt}, 8'd0);
        chk({tag, "_ale1"},    {7'd0, ALE1}, 8'd0);
        chk({tag, "_iowrreq"}, {7'd0, IOWRREQ}, 8'd0);
        chk({tag, "_lanes"},   {6'd0, IOL0, IOU0}, 8'd0);
        chk({tag, "_wrerr"},   {7'd0, WrErr}, 8'd0);
        chk({tag, "_postrdy"}, {7'd0, PostRdy}, 8'd1);
    endtask

    task automatic driveIdle();
        PostReq = 0; PostL = 0; PostU = 0; RdReq = 0; ErrClr = 0;
        IOACT = 0; IODONE = 0; IOBERR = 0;
    endtask

    // Monitor: every new write request must carry the lanes of the oldest
    // accepted post that has not yet been issued.
    initial begin : monitor
        logic       prevReq;
        logic [7:0] e;
        prevReq = 1'b0;
        forever begin
            @(negedge FCLK);
            if (IOWRREQ && !prevReq) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL issue_unexpected: got request expected none at t=%0t", $time);
                end else begin
                    e = expQ.pop_front();
                    chk("issue_lanes", {6'd0, IOL0, IOU0}, e);
                end
            end else if (!IOWRREQ) begin
                chk("idle_lanes", {6'd0, IOL0, IOU0}, 8'd0);
            end
            prevReq = IOWRREQ;
        end
    end

    initial begin : driver
        int   phase, age;
        bit   err, ale1Exp, resetDone;
        bit   s0Occ, s1Occ, expRdGnt, expPostRdy, accept;
        bit   retire, tmo, transfer, fillWin, slowMaster;
        int   nextPhase, nextAge;
        ent_t n;

        phase = P_IDLE; age = 0; err = 0; ale1Exp = 0; resetDone = 0;
        driveIdle();
        nRESin = 1'b0;
        #3;
        checkReset("por");
        @(negedge FCLK);
        nRESin = 1'b1;
        @(posedge FCLK);
        #1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            fillWin    = (cyc >= 1500) && (cyc < 1700);
            slowMaster = ((cyc / 300) % 2) == 1;

            if (!resetDone && fillWin && phase == P_ACT && ent.size() == 2) begin
                driveIdle();
                #2 nRESin = 1'b0;
                #1 checkReset("midrst");
                ent.delete();
                expQ.delete();
                phase = P_IDLE; age = 0; err = 0; ale1Exp = 0;
                resetDone = 1;
                @(negedge FCLK);
                nRESin = 1'b1;
                @(posedge FCLK);
                #1;
                continue;
            end

            if (fillWin && !resetDone) begin
                PostReq = 1; PostL = 1'($urandom); PostU = 1'($urandom);
                RdReq = 0; ErrClr = 0; IOACT = 1; IODONE = 0; IOBERR = 0;
            end else begin
                PostReq = ($urandom_range(0, 99) < 50);
                PostL   = 1'($urandom);
                PostU   = 1'($urandom);
                RdReq   = ($urandom_range(0, 99) < 20);
                ErrClr  = ($urandom_range(0, 99) < 15);
                IOACT   = ($urandom_range(0, 99) < (slowMaster ? 25 : 70));
                IODONE  = ($urandom_range(0, 99) < 60);
                IOBERR  = ($urandom_range(0, 99) < 30);
            end
            #1;

            s1Occ      = (ent.size() > 0) && ent[0].s1;
            s0Occ      = (ent.size() > 0) && !ent[ent.size()-1].s1;
            expRdGnt   = RdReq && (ent.size() == 0) && (phase == P_IDLE);
            expPostRdy = !s0Occ && !expRdGnt;
            accept     = PostReq && expPostRdy;

            chk("level",   {6'd0, Level}, 8'(ent.size()));
            chk("rdgnt",   {7'd0, RdGnt}, {7'd0, expRdGnt});
            chk("postrdy", {7'd0, PostRdy}, {7'd0, expPostRdy});
            chk("ale0",    {7'd0, ALE0}, {7'd0, accept});
            chk("ale1",    {7'd0, ALE1}, {7'd0, ale1Exp});
            chk("iowrreq", {7'd0, IOWRREQ}, {7'd0, (phase == P_REQ)});
            chk("wrerr",   {7'd0, WrErr}, {7'd0, err});

            retire = 0; tmo = 0; nextPhase = phase; nextAge = age;
            case (phase)
                P_IDLE: if (s1Occ) begin nextPhase = P_REQ; nextAge = 1; end
                P_REQ: begin
                    if (IOACT) begin nextPhase = P_ACT; nextAge = 1; end
                    else if (age == TMO_TB) begin tmo = 1; nextPhase = P_IDLE; end
                    else nextAge = age + 1;
                end
                default: begin
                    if (IODONE) begin retire = 1; nextPhase = P_IDLE; end
                    else if (age == TMO_TB) begin tmo = 1; nextPhase = P_IDLE; end
                    else nextAge = age + 1;
                end
            endcase

            if ((retire && IOBERR) || tmo) err = 1;
            else if (ErrClr) err = 0;

            transfer = s0Occ && !s1Occ;
            if (retire || tmo) ent.delete(0);
            if (transfer) ent[0].s1 = 1;
            if (accept) begin
                n.l = PostL; n.u = PostU; n.s1 = 0;
                ent.push_back(n);
                expQ.push_back({6'd0, PostL, PostU});
            end
            ale1Exp = transfer;
            phase   = nextPhase;
            age     = nextAge;

            @(posedge FCLK);
            #1;
        end

        if (!resetDone) begin
            checks++;
            errors++;
            $display("FAIL midrst_reach: got no ACT with two entries expected one within window");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
